sdram_arbit: RTL and testbench

SDRAM_ARBIT -- requirements
Module: sdram_arbit

---
 rtl/sdram_pkg.sv | 29 ++
 rtl/sdram_arbit_if.sv | 56 +++++
 rtl/sdram_arbit_sel.sv | 28 ++
 rtl/sdram_arbit.sv | 143 ++++++++++++++
 tb/tb_sdram_arbit.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings {cs_n,ras_n,cas_n,we_n},
// arbiter state encoding, requester indices and default bus widths.
package sdram_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_BANK_W = 2;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } arb_state_t;

    // Bit positions inside the request / grant vectors
    localparam int REQ_N   = 3;
    localparam int SEL_REF = 0;
    localparam int SEL_WR  = 1;
    localparam int SEL_RD  = 2;

endpackage

// File: rtl/sdram_arbit_if.sv
// Bundle of all requester-side and pin-side signals of the SDRAM arbiter.
// slave = arbiter side, master = init/refresh/write/read engines and pins.
interface sdram_arbit_if
    import sdram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BANK_W = DEF_BANK_W
);
    logic              flag_init_end;
    logic [3:0]        init_cmd;
    logic [ADDR_W-1:0] init_addr;

    logic              ref_req;
    logic              ref_en;
    logic              flag_ref_end;
    logic [3:0]        aref_cmd;
    logic [ADDR_W-1:0] aref_addr;

    logic              wr_req;
    logic              wr_en;
    logic              flag_wr_end;
    logic [3:0]        wr_cmd;
    logic [ADDR_W-1:0] wr_addr;
    logic [BANK_W-1:0] wr_bank;

    logic              rd_req;
    logic              rd_en;
    logic              flag_rd_end;
    logic [3:0]        rd_cmd;
    logic [ADDR_W-1:0] rd_addr;
    logic [BANK_W-1:0] rd_bank;

    logic [3:0]        sdram_cmd;
    logic [ADDR_W-1:0] sdram_addr;
    logic [BANK_W-1:0] sdram_bank;
    logic [2:0]        arb_state;

    modport slave (
        input  flag_init_end, init_cmd, init_addr,
        input  ref_req, flag_ref_end, aref_cmd, aref_addr,
        input  wr_req, flag_wr_end, wr_cmd, wr_addr, wr_bank,
        input  rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank,
        output ref_en, wr_en, rd_en,
        output sdram_cmd, sdram_addr, sdram_bank, arb_state
    );

    modport master (
        output flag_init_end, init_cmd, init_addr,
        output ref_req, flag_ref_end, aref_cmd, aref_addr,
        output wr_req, flag_wr_end, wr_cmd, wr_addr, wr_bank,
        output rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank,
        input  ref_en, wr_en, rd_en,
        input  sdram_cmd, sdram_addr, sdram_bank, arb_state
    );

endinterface

// File: rtl/sdram_arbit_sel.sv
// Grant picker: refresh always wins; a write/read tie goes to the opposite
// of the last granted of the two (last_rd=1 means read was granted last).
module sdram_arbit_sel
    import sdram_pkg::*;
(
    input  logic [REQ_N-1:0] req,
    input  logic             last_rd,
    output logic [REQ_N-1:0] pick
);

    always_comb begin
        pick = '0;
        if (req[SEL_REF]) begin
            pick[SEL_REF] = 1'b1;
        end else if (req[SEL_WR] && req[SEL_RD]) begin
            if (last_rd) begin
                pick[SEL_WR] = 1'b1;
            end else begin
                pick[SEL_RD] = 1'b1;
            end
        end else if (req[SEL_WR]) begin
            pick[SEL_WR] = 1'b1;
        end else if (req[SEL_RD]) begin
            pick[SEL_RD] = 1'b1;
        end
    end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: INIT until init completes, then grants refresh,
// write or read bursts one at a time. Define SDRAM_ARBIT_RR_EN for write/read round robin.
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BANK_W = DEF_BANK_W
) (
    input  logic         clk,
    input  logic         rst_n,
    sdram_arbit_if.slave bus
);

    arb_state_t        state_reg;
    arb_state_t        state_next;
    logic [REQ_N-1:0]  grant_reg;
    logic [REQ_N-1:0]  grant_next;
    logic [REQ_N-1:0]  req_vec;
    logic [REQ_N-1:0]  pick;
    logic              last_rd;

    logic [3:0]        cmd_mux;
    logic [ADDR_W-1:0] addr_mux;
    logic [BANK_W-1:0] bank_mux;

    assign req_vec = {bus.rd_req, bus.wr_req, bus.ref_req};

`ifdef SDRAM_ARBIT_RR_EN
    logic ptr_reg;
    logic ptr_next;

    // Pointer remembers whether read (1) or write (0) was granted last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= 1'b1;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (grant_next[SEL_WR]) begin
            ptr_next = 1'b0;
        end else if (grant_next[SEL_RD]) begin
            ptr_next = 1'b1;
        end
    end

    assign last_rd = ptr_reg;
`else
    // Fixed priority: behave as if read was always last, so write wins ties
    assign last_rd = 1'b1;
`endif

    sdram_arbit_sel u_sel (
        .req     (req_vec),
        .last_rd (last_rd),
        .pick    (pick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_INIT;
            grant_reg <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
        end
    end

    // Grants are only produced leaving ARBIT, so they land in the first
    // cycle of the burst state and are never adjacent.
    always_comb begin
        state_next = state_reg;
        grant_next = '0;
        case (state_reg)
            ST_INIT: begin
                if (bus.flag_init_end) state_next = ST_ARBIT;
            end
            ST_ARBIT: begin
                grant_next = pick;
                if (pick[SEL_REF])     state_next = ST_AREF;
                else if (pick[SEL_WR]) state_next = ST_WRITE;
                else if (pick[SEL_RD]) state_next = ST_READ;
            end
            ST_AREF: begin
                if (bus.flag_ref_end) state_next = ST_ARBIT;
            end
            ST_WRITE: begin
                if (bus.flag_wr_end) state_next = ST_ARBIT;
            end
            ST_READ: begin
                if (bus.flag_rd_end) state_next = ST_ARBIT;
            end
            default: state_next = ST_INIT;
        endcase
    end

    // Pin mux follows the state; reset forces a NOP regardless of state
    always_comb begin
        cmd_mux  = CMD_NOP;
        addr_mux = '0;
        bank_mux = '0;
        if (rst_n) begin
            case (state_reg)
                ST_INIT: begin
                    cmd_mux  = bus.init_cmd;
                    addr_mux = bus.init_addr;
                end
                ST_AREF: begin
                    cmd_mux  = bus.aref_cmd;
                    addr_mux = bus.aref_addr;
                end
                ST_WRITE: begin
                    cmd_mux  = bus.wr_cmd;
                    addr_mux = bus.wr_addr;
                    bank_mux = bus.wr_bank;
                end
                ST_READ: begin
                    cmd_mux  = bus.rd_cmd;
                    addr_mux = bus.rd_addr;
                    bank_mux = bus.rd_bank;
                end
                default: begin
                    cmd_mux  = CMD_NOP;
                    addr_mux = '0;
                    bank_mux = '0;
                end
            endcase
        end
    end

    assign bus.sdram_cmd  = cmd_mux;
    assign bus.sdram_addr = addr_mux;
    assign bus.sdram_bank = bank_mux;
    assign bus.arb_state  = state_reg;

    assign bus.ref_en = grant_reg[SEL_REF];
    assign bus.wr_en  = grant_reg[SEL_WR];
    assign bus.rd_en  = grant_reg[SEL_RD];

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: expected grants are queued as requests are
// driven and checked by a grant monitor; state and pin mux are checked inline.
module tb_sdram_arbit;
    import sdram_pkg::*;

    localparam int AW = 12;
    localparam int BW = 2;

    logic clk;
    logic rst_n;

    sdram_arbit_if #(.ADDR_W(AW), .BANK_W(BW)) bus ();

    sdram_arbit #(.ADDR_W(AW), .BANK_W(BW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    bit prev_any = 1'b0;
    logic [2:0] mon_g;
    int mon_code;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Grant monitor: one-hot, never in consecutive cycles, matches scoreboard
    always @(negedge clk) begin
        mon_g = {bus.rd_en, bus.wr_en, bus.ref_en};
        if (mon_g != 3'b000) begin
            $display("grant %s at t=%0t", (mon_g == 3'b001) ? "ref" :
                     (mon_g == 3'b010) ? "wr" : (mon_g == 3'b100) ? "rd" : "multi", $time);
            check("grant_onehot", $countones(mon_g), 1);
            check("grant_gap", {31'd0, prev_any}, 0);
            if (exp_q.size() == 0) begin
                check("grant_unexpected", {29'd0, mon_g}, 0);
            end else begin
                mon_code = exp_q.pop_front();
                check("grant_kind", {29'd0, mon_g}, 32'd1 << mon_code);
            end
        end
        prev_any = |mon_g;
    end

    int exp_code;

    initial begin
        rst_n             = 1'b0;
        bus.flag_init_end = 1'b0;
        bus.init_cmd      = CMD_PRE;
        bus.init_addr     = 12'h400;
        bus.ref_req       = 1'b0;
        bus.flag_ref_end  = 1'b0;
        bus.aref_cmd      = CMD_AREF;
        bus.aref_addr     = 12'h0AB;
        bus.wr_req        = 1'b0;
        bus.flag_wr_end   = 1'b0;
        bus.wr_cmd        = CMD_WR;
        bus.wr_addr       = 12'h123;
        bus.wr_bank       = 2'd2;
        bus.rd_req        = 1'b0;
        bus.flag_rd_end   = 1'b0;
        bus.rd_cmd        = CMD_RD;
        bus.rd_addr       = 12'h321;
        bus.rd_bank       = 2'd1;

        // Reset state
        tick(2);
        check("rst_state", {29'd0, bus.arb_state}, ST_INIT);
        check("rst_cmd", {28'd0, bus.sdram_cmd}, CMD_NOP);
        check("rst_addr", {20'd0, bus.sdram_addr}, 0);
        check("rst_bank", {30'd0, bus.sdram_bank}, 0);
        check("rst_grants", {29'd0, bus.rd_en, bus.wr_en, bus.ref_en}, 0);

        // INIT: init command on pins, requests ignored until init done
        rst_n      = 1'b1;
        bus.wr_req = 1'b1;
        tick(1);
        check("init_cmd", {28'd0, bus.sdram_cmd}, CMD_PRE);
        check("init_addr", {20'd0, bus.sdram_addr}, 12'h400);
        tick(8);
        check("init_hold", {29'd0, bus.arb_state}, ST_INIT);
        bus.wr_req = 1'b0;
        tick(1);
        bus.flag_init_end = 1'b1;
        check("init_before_flag", {29'd0, bus.arb_state}, ST_INIT);
        tick(1);
        check("init_to_arbit", {29'd0, bus.arb_state}, ST_ARBIT);
        check("arbit_nop", {28'd0, bus.sdram_cmd}, CMD_NOP);

        // All three requests together: refresh first, then write
        bus.ref_req = 1'b1;
        bus.wr_req  = 1'b1;
        bus.rd_req  = 1'b1;
        exp_q.push_back(SEL_REF);
        tick(1);
        check("aref_state", {29'd0, bus.arb_state}, ST_AREF);
        check("aref_cmd", {28'd0, bus.sdram_cmd}, CMD_AREF);
        check("aref_addr", {20'd0, bus.sdram_addr}, 12'h0AB);
        check("aref_bank", {30'd0, bus.sdram_bank}, 0);
        bus.ref_req = 1'b0;
        tick(2);
        check("aref_hold", {29'd0, bus.arb_state}, ST_AREF);
        bus.flag_ref_end = 1'b1;
        exp_q.push_back(SEL_WR);
        tick(1);
        bus.flag_ref_end = 1'b0;
        check("aref_to_arbit", {29'd0, bus.arb_state}, ST_ARBIT);
        check("gap_nop", {28'd0, bus.sdram_cmd}, CMD_NOP);
        tick(1);
        check("write_state", {29'd0, bus.arb_state}, ST_WRITE);
        check("write_bank", {30'd0, bus.sdram_bank}, 2'd2);
        check("write_addr", {20'd0, bus.sdram_addr}, 12'h123);
        bus.wr_req = 1'b0;

        // Eight-cycle write; foreign end flags in the middle are ignored
        for (int i = 0; i < 8; i++) begin
            check("write_cmd", {28'd0, bus.sdram_cmd}, CMD_WR);
            if (i == 3) begin
                bus.flag_ref_end = 1'b1;
                bus.flag_rd_end  = 1'b1;
            end
            if (i == 4) begin
                bus.flag_ref_end = 1'b0;
                bus.flag_rd_end  = 1'b0;
            end
            if (i == 7) bus.flag_wr_end = 1'b1;
            tick(1);
        end
        bus.flag_wr_end = 1'b0;
        check("write_end_state", {29'd0, bus.arb_state}, ST_ARBIT);
        check("write_end_nop", {28'd0, bus.sdram_cmd}, CMD_NOP);

        // Held read request is served; end flag in grant cycle ends burst
        exp_q.push_back(SEL_RD);
        tick(1);
        check("read_state", {29'd0, bus.arb_state}, ST_READ);
        check("read_cmd", {28'd0, bus.sdram_cmd}, CMD_RD);
        check("read_addr", {20'd0, bus.sdram_addr}, 12'h321);
        check("read_bank", {30'd0, bus.sdram_bank}, 2'd1);
        bus.rd_req      = 1'b0;
        bus.flag_rd_end = 1'b1;
        tick(1);
        bus.flag_rd_end = 1'b0;
        check("read_short_end", {29'd0, bus.arb_state}, ST_ARBIT);

        // Write and read held together
        bus.wr_req = 1'b1;
        bus.rd_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef SDRAM_ARBIT_RR_EN
            exp_code = (k % 2 == 0) ? SEL_WR : SEL_RD;
`else
            exp_code = SEL_WR;
`endif
            exp_q.push_back(exp_code);
            tick(1);
            check("tie_state", {29'd0, bus.arb_state},
                  (exp_code == SEL_WR) ? ST_WRITE : ST_READ);
            bus.flag_wr_end = 1'b1;
            bus.flag_rd_end = 1'b1;
            tick(1);
            bus.flag_wr_end = 1'b0;
            bus.flag_rd_end = 1'b0;
            check("tie_back", {29'd0, bus.arb_state}, ST_ARBIT);
        end
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;

        // Asynchronous reset in the middle of a write
        bus.wr_req = 1'b1;
        exp_q.push_back(SEL_WR);
        tick(1);
        check("pre_rst_write", {29'd0, bus.arb_state}, ST_WRITE);
        bus.wr_req = 1'b0;
        tick(2);
        bus.flag_init_end = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_state", {29'd0, bus.arb_state}, ST_INIT);
        check("arst_cmd", {28'd0, bus.sdram_cmd}, CMD_NOP);
        check("arst_addr", {20'd0, bus.sdram_addr}, 0);
        check("arst_bank", {30'd0, bus.sdram_bank}, 0);
        check("arst_grants", {29'd0, bus.rd_en, bus.wr_en, bus.ref_en}, 0);
        tick(1);
        check("arst_hold", {29'd0, bus.arb_state}, ST_INIT);
        rst_n      = 1'b1;
        bus.wr_req = 1'b1;
        tick(3);
        check("reinit_hold", {29'd0, bus.arb_state}, ST_INIT);
        check("reinit_cmd", {28'd0, bus.sdram_cmd}, CMD_PRE);
        bus.flag_init_end = 1'b1;
        tick(1);
        check("reinit_arbit", {29'd0, bus.arb_state}, ST_ARBIT);
        exp_q.push_back(SEL_WR);
        tick(1);
        check("reinit_write", {29'd0, bus.arb_state}, ST_WRITE);
        bus.wr_req      = 1'b0;
        bus.flag_wr_end = 1'b1;
        tick(1);
        bus.flag_wr_end = 1'b0;
        check("final_arbit", {29'd0, bus.arb_state}, ST_ARBIT);
        tick(2);
        check("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
